fifo_rr_reader: RTL
===================

# fifo_rr_reader

Round-robin read-side arbiter that drains four upstream FIFOs into four downstream FIFOs. It issues at most one `read` per cycle to a non-empty upstream FIFO and captures the registered word that FIFO returns with `valid`. It routes the word to the downstream FIFO selected by the word's two MSBs, and stalls whenever any downstream FIFO reports `almost_full`. It sits between the input FIFO bank and the output FIFO bank of the datapath and is the consumer of the FIFO read interface.

## Interface
- `DATA_SIZE`, 12, word width; bits `[DATA_SIZE-1:DATA_SIZE-2]` are the destination field.
- `NUM_FIFOS`, 4, upstream and downstream FIFO count; fixed at 4 because the destination field is 2 bits.
- `clk`  in  1  single clock, rising edge.
- `reset_L`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  arbiter enable; when low, no new reads are issued.
- `fifo_empty`  in  4  upstream empty flags, combinational from upstream count.
- `fifo_valid`  in  4  upstream `valid`, high the cycle after an accepted read.
- `fifo_data`  in  4*DATA_SIZE  upstream `fifo_data_out`, flattened; FIFO i is slice `[i*DATA_SIZE +: DATA_SIZE]`.
- `out_almost_full`  in  4  downstream almost-full flags.
- `read`  out  4  one-hot read strobe to upstream, combinational.
- `push`  out  4  one-hot write strobe to downstream, registered.
- `data_out`  out  DATA_SIZE  word to downstream, registered, shared by all four.
- `idle`  out  1  high when the FSM is IDLE and no word is in flight, registered.
- `words_fwd`  out  16  count of forwarded words, registered, wraps at 2^16.

## Operation
- FSM states: IDLE, RUN, PAUSE. State resets to IDLE.
- Transitions from IDLE:
  - IDLE->RUN when `enable` is high, at least one `fifo_empty` is low, and all `out_almost_full` are low.
  - IDLE->PAUSE when `enable` is high, at least one `fifo_empty` is low, and any `out_almost_full` is high.
- Transitions from RUN:
  - RUN->PAUSE when any `out_almost_full` is high.
  - RUN->IDLE when all `fifo_empty` are high, or `enable` is low.
- Transitions from PAUSE:
  - PAUSE->RUN when all `out_almost_full` are low, a FIFO is non-empty, and `enable` is high.
  - PAUSE->IDLE when all `out_almost_full` are low and (all FIFOs are empty or `enable` is low).
- Read issue (combinational):
  - `read[g]` is high only when state is RUN, `enable` is high, all `out_almost_full` are low, and `fifo_empty[g]` is low.
  - Grant `g` is the first non-empty index strictly after `rr_ptr`, searched modulo 4 and wrapping; `rr_ptr` itself is checked last.
  - `rr_ptr` loads `g` on every issued read. It holds otherwise. It resets to 3, so FIFO 0 is first.
  - Because the stall term is in the read expression, stalling takes effect in the same cycle `out_almost_full` rises, not one cycle later.
- In-flight stage: on an issued read, register `rd_sel`<=g and `rd_pend`<=1. Otherwise `rd_pend`<=0.
- Capture:
  - When `rd_pend` is high and `fifo_valid[rd_sel]` is high: `data_out`<=slice `rd_sel` of `fifo_data`, `push`<=onehot(dest field), `words_fwd`<=`words_fwd`+1.
  - Otherwise `push`<=0 and `data_out` holds.
- When `rd_pend` is high but `fifo_valid[rd_sel]` is low, nothing is pushed and the word is dropped. This is not flagged.
- A word already in flight when a stall begins is still captured and pushed. Downstream `almost_full` thresholds must therefore leave at least 2 free entries.
- `idle` = (state==IDLE) && !`rd_pend` && (`push`==0).

## Timing
- Reset: asynchronous, active-low. While `reset_L` is low: state=IDLE, `rr_ptr`=3, `rd_pend`=0, `push`=0, `data_out`=0, `words_fwd`=0, `idle`=1. `read` is held at 0 because state is IDLE.
- Latency: read at cycle N -> upstream `valid`/data at N+1 -> `push` and `data_out` at N+2.
- Throughput: 1 word/cycle sustained while in RUN.
- A single non-empty FIFO can be read on consecutive cycles. Upstream `fifo_empty` updates at the same edge that samples `read`, so a one-entry FIFO is read exactly once.
- Reset asserted mid-transfer discards in-flight words; no `push` follows reset release.
- Simultaneous `out_almost_full` rise and `fifo_empty` fall: stall wins, no read, and the FSM enters PAUSE.

## Test plan
- **Reset:** `reset_L`=0 at an arbitrary mid-transfer point -> `push`=0, `read`=0, `data_out`=0, `words_fwd`=0, `idle`=1 immediately, without waiting for a clock edge.
- **Rotation:** all four FIFOs hold 2 words; `enable`=1 -> reads issue 0,1,2,3,0,1,2,3 on 8 consecutive cycles; first `push` 2 cycles after the first read; `words_fwd`=8; FSM returns to IDLE.
- **Skip empty:** only FIFOs 1 and 3 are non-empty, with 3 words each -> read order 1,3,1,3,1,3; no read to FIFO 0 or 2.
- **Routing:** word 0xC05 arrives from FIFO 2 -> `push`=4'b1000, `data_out`=0xC05. Word 0x3FF -> `push`=4'b0001.
- **Backpressure:** raise `out_almost_full[2]` mid-stream -> `read`=0 in the same cycle; at most 1 in-flight `push` follows; FSM is in PAUSE. Drop the flag -> RUN resumes at the next grant in round-robin order.
- **Single entry:** one FIFO holds 1 word -> exactly one `read` pulse, one `push`, then IDLE and `idle`=1 three cycles after the read.

Source files
------------

// File: rtl/fifo_rr_reader.sv
// Round-robin read arbiter: drains four upstream FIFOs into four downstream
// FIFOs, routing each word by its two MSBs and stalling on downstream almost-full.
module fifo_rr_reader #(
    parameter int DATA_SIZE = 12,
    parameter int NUM_FIFOS = 4
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           enable,
    input  logic [NUM_FIFOS-1:0]           fifo_empty,
    input  logic [NUM_FIFOS-1:0]           fifo_valid,
    input  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data,
    input  logic [NUM_FIFOS-1:0]           out_almost_full,
    output logic [NUM_FIFOS-1:0]           read,
    output logic [NUM_FIFOS-1:0]           push,
    output logic [DATA_SIZE-1:0]           data_out,
    output logic                           idle,
    output logic [15:0]                    words_fwd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    function automatic logic [NUM_FIFOS-1:0] onehot4(input logic [1:0] sel);
        logic [NUM_FIFOS-1:0] v;
        case (sel)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic [1:0]             rr_ptr_r;
    logic [1:0]             grant_s;
    logic [1:0]             scan_idx_s;
    logic                   grant_vld_s;
    logic                   stall_s;
    logic                   any_ready_s;
    logic                   issue_s;
    logic                   rd_pend_r;
    logic [1:0]             rd_sel_r;
    logic                   cap_s;
    logic [DATA_SIZE-1:0]   cap_word_s;
    logic [NUM_FIFOS-1:0]   push_r;
    logic [NUM_FIFOS-1:0]   push_next_s;
    logic [DATA_SIZE-1:0]   data_out_r;
    logic [DATA_SIZE-1:0]   data_next_s;
    logic [15:0]            words_fwd_r;
    logic [15:0]            words_next_s;
    logic                   idle_r;
    logic                   idle_next_s;

    assign stall_s     = |out_almost_full;
    assign any_ready_s = ~(&fifo_empty);
    // Stall is part of the issue term so a rising almost-full blocks reads in the same cycle.
    assign issue_s     = (state_r == RUN) && enable && !stall_s && grant_vld_s;
    assign read        = issue_s ? onehot4(grant_s) : {NUM_FIFOS{1'b0}};
    assign cap_s       = rd_pend_r && fifo_valid[rd_sel_r];
    assign cap_word_s  = fifo_data[int'(rd_sel_r)*DATA_SIZE +: DATA_SIZE];

    assign push      = push_r;
    assign data_out  = data_out_r;
    assign words_fwd = words_fwd_r;
    assign idle      = idle_r;

    // Round-robin scan: offsets 4..1 from rr_ptr, the last (smallest offset) hit wins.
    always_comb begin
        grant_s     = rr_ptr_r;
        grant_vld_s = 1'b0;
        scan_idx_s  = rr_ptr_r;
        for (int off = NUM_FIFOS; off >= 1; off--) begin
            scan_idx_s  = rr_ptr_r + 2'(off);
            grant_s     = fifo_empty[scan_idx_s] ? grant_s : scan_idx_s;
            grant_vld_s = grant_vld_s | ~fifo_empty[scan_idx_s];
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable && any_ready_s) begin
                    state_next_s = stall_s ? PAUSE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (stall_s) begin
                    state_next_s = PAUSE;
                end else if (!any_ready_s || !enable) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            PAUSE: begin
                if (stall_s) begin
                    state_next_s = PAUSE;
                end else if (enable && any_ready_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Capture stage next values; idle is derived from next-cycle values so it is exact when registered.
    always_comb begin
        push_next_s  = {NUM_FIFOS{1'b0}};
        data_next_s  = data_out_r;
        words_next_s = words_fwd_r;
        if (cap_s) begin
            push_next_s  = onehot4(cap_word_s[DATA_SIZE-1 -: 2]);
            data_next_s  = cap_word_s;
            words_next_s = words_fwd_r + 16'd1;
        end else begin
            push_next_s  = {NUM_FIFOS{1'b0}};
            data_next_s  = data_out_r;
            words_next_s = words_fwd_r;
        end
        idle_next_s = (state_next_s == IDLE) && !issue_s && (push_next_s == {NUM_FIFOS{1'b0}});
    end

    // State, pointer, in-flight and output registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 2'd3;
            rd_pend_r   <= 1'b0;
            rd_sel_r    <= 2'd0;
            push_r      <= {NUM_FIFOS{1'b0}};
            data_out_r  <= {DATA_SIZE{1'b0}};
            words_fwd_r <= 16'd0;
            idle_r      <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            rd_pend_r   <= issue_s;
            if (issue_s) begin
                rr_ptr_r <= grant_s;
                rd_sel_r <= grant_s;
            end
            push_r      <= push_next_s;
            data_out_r  <= data_next_s;
            words_fwd_r <= words_next_s;
            idle_r      <= idle_next_s;
        end
    end

endmodule
